ann_param_loader: RTL and testbench

//  Sequencer that streams one parameter/image block from a dual-port ROM into the classifier's register arrays.

---
 rtl/ann_pkg.sv | 25 ++
 rtl/ann_loader_delay.sv | 39 +++
 rtl/ann_param_loader.sv | 184 ++++++++++++++++++
 tb/tb_ann_param_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared definitions for the ANN parameter loaders.
// Holds the default bus widths, the loader FSM state encoding and the
// per-ROM block lengths (in words) used when the loaders are instantiated.
package ann_pkg;

   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_ADDR_W  = 16;
   localparam int unsigned DEF_IDX_W   = 10;
   localparam int unsigned DEF_ROM_LAT = 2;

   // Block lengths, one per ROM
   localparam int unsigned IMG_LEN = 64;
   localparam int unsigned W01_LEN = 512;
   localparam int unsigned B01_LEN = 8;
   localparam int unsigned W12_LEN = 16;
   localparam int unsigned B12_LEN = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ann_loader_delay.sv
// ROM read-latency tracker: DEPTH-stage shift register carrying
// {valid, last_b_valid, idx} alongside the outstanding ROM reads.
// Ports:
//   clk, reset  clock / async active-high reset
//   din         tag entering with the addresses driven this edge
//   dout        tag aligned with the ROM data (last stage)
//   pend_c      a tag is still in stages 0..DEPTH-2 (combinational)
module ann_loader_delay #(
   parameter int unsigned W     = 12,
   parameter int unsigned DEPTH = 2
)(
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         pend_c
);

   logic [W-1:0] stage [DEPTH];

   // Shift tags one stage per clock
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

   // Only the stages before the last count: the last one is consumed this edge
   always_comb begin
      pend_c = 1'b0;
      for (int i = 0; i + 1 < int'(DEPTH); i++) pend_c = pend_c | stage[i][W-1];
   end

endmodule

// File: rtl/ann_param_loader.sv
// Streams one parameter/image block from a dual-port ROM into the classifier
// register arrays, two words (even on port A, odd on port B) per clock.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running checksum output.
// Ports:
//   clk, reset              clock / async active-high reset
//   start, base_addr, len   load request (sampled in IDLE)
//   rom_addr_a/b, rom_q_a/b ROM ports (A even word, B odd word)
//   wr_en_a/b, wr_idx       write strobes, even destination index
//   wr_data_a/b             registered ROM data
//   busy, done, loaded      status
//   checksum                modulo-2^DATA_W sum of written words (optional)
module ann_param_loader
   import ann_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned IDX_W   = DEF_IDX_W,
   parameter int unsigned ROM_LAT = DEF_ROM_LAT
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [IDX_W-1:0]  len,
   output logic [ADDR_W-1:0] rom_addr_a,
   output logic [ADDR_W-1:0] rom_addr_b,
   input  logic [DATA_W-1:0] rom_q_a,
   input  logic [DATA_W-1:0] rom_q_b,
   output logic              wr_en_a,
   output logic              wr_en_b,
   output logic [IDX_W-1:0]  wr_idx,
   output logic [DATA_W-1:0] wr_data_a,
   output logic [DATA_W-1:0] wr_data_b,
   output logic              busy,
   output logic              done,
   output logic              loaded
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam int unsigned CW = IDX_W + 1;   // word counter, reaches len+1
   localparam int unsigned PW = IDX_W + 2;   // pipe tag {valid, b_valid, idx}

   state_t           state, state_next;
   logic [IDX_W-1:0] len_q;
   logic [CW-1:0]    cnt;                    // even index of the next pair
   logic [CW-1:0]    len_ext;
   logic             accept_c, issue_c, issue_b_c;
   logic [IDX_W-1:0] issue_idx_c;
   logic [PW-1:0]    pipe_out;
   logic             pend_c;
   logic             pipe_v, pipe_b;
   logic [IDX_W-1:0] pipe_idx;

   assign len_ext  = CW'(len_q);
   assign pipe_v   = pipe_out[PW-1];
   assign pipe_b   = pipe_out[PW-2];
   assign pipe_idx = pipe_out[IDX_W-1:0];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next state and issue control; pair 0 is issued on the start edge itself
   always_comb begin
      state_next  = state;
      accept_c    = 1'b0;
      issue_c     = 1'b0;
      issue_b_c   = 1'b0;
      issue_idx_c = '0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               accept_c = 1'b1;
               if (len == '0) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_FETCH;
                  issue_c    = 1'b1;
                  issue_b_c  = (len != IDX_W'(1));
               end
            end
         end
         ST_FETCH: begin
            if (cnt < len_ext) begin
               issue_c     = 1'b1;
               issue_idx_c = cnt[IDX_W-1:0];
               issue_b_c   = (cnt + CW'(1)) < len_ext;
               if ((cnt + CW'(2)) >= len_ext) state_next = ST_DRAIN;
            end else begin
               // Only reached for a single-pair block
               state_next = pend_c ? ST_DRAIN : ST_DONE;
            end
         end
         ST_DRAIN: begin
            if (!pend_c) state_next = ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   ann_loader_delay #(
      .W     (PW),
      .DEPTH (ROM_LAT)
   ) u_delay (
      .clk    (clk),
      .reset  (reset),
      .din    ({issue_c, issue_b_c, issue_idx_c}),
      .dout   (pipe_out),
      .pend_c (pend_c)
   );

   // Addresses, counters, write port and status registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q      <= '0;
         cnt        <= '0;
         rom_addr_a <= '0;
         rom_addr_b <= '0;
         wr_en_a    <= 1'b0;
         wr_en_b    <= 1'b0;
         wr_idx     <= '0;
         wr_data_a  <= '0;
         wr_data_b  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         loaded     <= 1'b0;
      end else begin
         busy <= (state != ST_IDLE);
         done <= (state == ST_DONE);
         if (accept_c)               loaded <= 1'b0;
         else if (state == ST_DONE)  loaded <= 1'b1;

         if (accept_c) begin
            len_q <= len;
            cnt   <= CW'(2);
         end else if (issue_c) begin
            cnt   <= cnt + CW'(2);
         end

         // Address arithmetic wraps modulo 2^ADDR_W
         if (issue_c) begin
            if (state == ST_IDLE) begin
               rom_addr_a <= base_addr;
               rom_addr_b <= base_addr + ADDR_W'(1);
            end else begin
               rom_addr_a <= rom_addr_a + ADDR_W'(2);
               rom_addr_b <= rom_addr_b + ADDR_W'(2);
            end
         end

         wr_en_a <= pipe_v;
         wr_en_b <= pipe_v & pipe_b;
         if (pipe_v) begin
            wr_idx    <= pipe_idx;
            wr_data_a <= rom_q_a;
         end
         if (pipe_v & pipe_b) wr_data_b <= rom_q_b;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running sum of written words, settles together with the last write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         checksum <= '0;
      end else if (accept_c) begin
         checksum <= '0;
      end else if (pipe_v) begin
         checksum <= checksum + rom_q_a + (pipe_b ? rom_q_b : DATA_W'(0));
      end
   end
`endif

endmodule

// File: tb/tb_ann_param_loader.sv
// Bench for ann_param_loader: ROM returns its own address as data (q=addr),
// expected writes/done events go into a scoreboard queue tagged with the
// clock edge after which they must appear; a monitor pops and compares.
module tb_ann_param_loader;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic [9:0]  len = '0;
   logic [15:0] rom_addr_a, rom_addr_b;
   logic [31:0] rom_q_a = '0, rom_q_b = '0;
   logic        wr_en_a, wr_en_b, busy, done, loaded;
   logic [9:0]  wr_idx;
   logic [31:0] wr_data_a, wr_data_b;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      bit          is_done;
      logic [9:0]  idx;
      bit          en_b;
      logic [31:0] da;
      logic [31:0] db;
   } ev_t;

   ev_t sbq[$];

   ann_param_loader #(
      .DATA_W(32), .ADDR_W(16), .IDX_W(10), .ROM_LAT(LAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
      .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
      .rom_q_a(rom_q_a), .rom_q_b(rom_q_b),
      .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_idx(wr_idx),
      .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
      .busy(busy), .done(done), .loaded(loaded)
`ifdef LOADER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous ROM, one register stage: address-to-data latency of 2 as seen by the loader
   always @(posedge clk) begin
      rom_q_a <= {16'h0000, rom_addr_a};
      rom_q_b <= {16'h0000, rom_addr_b};
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", nm, act, want, cyc);
      end
   endtask

   task automatic push_pair(input int c, input logic [9:0] idx, input bit eb, input logic [15:0] a);
      ev_t e;
      e.cyc = c; e.is_done = 1'b0; e.idx = idx; e.en_b = eb;
      e.da = {16'h0000, a};
      e.db = {16'h0000, a + 16'd1};
      sbq.push_back(e);
   endtask

   task automatic push_done(input int c);
      ev_t e;
      e.cyc = c; e.is_done = 1'b1; e.idx = '0; e.en_b = 1'b0; e.da = '0; e.db = '0;
      sbq.push_back(e);
   endtask

   // Pair i written after edge e0+i+LAT; done one edge after the last pair
   task automatic push_load(input int e0, input logic [15:0] b, input logic [9:0] l);
      int p;
      p = (int'(l) + 1) / 2;
      for (int i = 0; i < p; i++)
         push_pair(e0 + i + LAT, 10'(2 * i), (2 * i + 1) < int'(l), b + 16'(2 * i));
      if (l == 10'd0) push_done(e0 + 1);
      else            push_done(e0 + p + LAT);
   endtask

   task automatic wait_empty(input string nm);
      for (int k = 0; k < 200; k++) begin
         if (sbq.size() == 0) break;
         @(negedge clk);
      end
      chk(nm, 64'(sbq.size()), 64'(0));
   endtask

   task automatic run_load(input logic [15:0] b, input logic [9:0] l);
      int e0, exp_busy, nbusy;
      exp_busy = (l == 10'd0) ? 1 : (int'(l) + 1) / 2 + LAT;
      @(negedge clk);
      start = 1'b1; base_addr = b; len = l;
      e0 = cyc + 1;
      push_load(e0, b, l);
      nbusy = 0;
      for (int k = 0; k < exp_busy + 4; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0;
            chk("loaded_clear", 64'(loaded), 64'(0));
         end
         if (busy) nbusy++;
      end
      chk("busy_cycles", 64'(nbusy), 64'(exp_busy));
      chk("loaded_set", 64'(loaded), 64'(1));
      wait_empty("sb_drained");
   endtask

   // Monitor: every strobe or done must match the head of the scoreboard
   always @(negedge clk) begin : mon
      ev_t e;
      if (!reset && (wr_en_a || wr_en_b || done)) begin
         if (sbq.size() == 0) begin
            chk("unexpected_event", 64'({wr_en_a, wr_en_b, done}), 64'(0));
         end else begin
            e = sbq.pop_front();
            chk("event_cycle", 64'(cyc), 64'(e.cyc));
            if (e.is_done) begin
               chk("done_strobes", 64'({wr_en_a, wr_en_b, done}), 64'(3'b001));
            end else begin
               chk("wr_strobes", 64'({wr_en_a, wr_en_b, done}), 64'({1'b1, e.en_b, 1'b0}));
               chk("wr_idx", 64'(wr_idx), 64'(e.idx));
               chk("wr_data_a", 64'(wr_data_a), 64'(e.da));
               if (e.en_b) chk("wr_data_b", 64'(wr_data_b), 64'(e.db));
            end
         end
      end
   end

   task automatic chk_all_zero(input string nm);
      chk(nm, 64'({wr_en_a, wr_en_b, busy, done, loaded}), 64'(0));
      chk({nm, "_data"}, {wr_data_a, wr_data_b}, 64'(0));
      chk({nm, "_addr"}, 64'({rom_addr_a, rom_addr_b, 6'd0, wr_idx}), 64'(0));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int e0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset_state");
      reset = 1'b0;

      // 1: len=8 from 0x0000
      run_load(16'h0000, 10'd8);
      chk("t1_last_idx", 64'(wr_idx), 64'(6));
      chk("t1_last_b", 64'(wr_data_b), 64'(7));
      chk("t1_addr_hold", 64'({rom_addr_a, rom_addr_b}), 64'({16'h0006, 16'h0007}));

      // 2: odd length, final pair has no port-B write
      run_load(16'h0100, 10'd5);
      chk("t2_last_a", 64'(wr_data_a), 64'(32'h0000_0104));

      // 3: empty block
      run_load(16'h0040, 10'd0);

      // 4: reset in the middle of a long load
      @(negedge clk);
      start = 1'b1; base_addr = 16'h1000; len = 10'd512;
      e0 = cyc + 1;
      push_pair(e0 + 2, 10'd0, 1'b1, 16'h1000);
      push_pair(e0 + 3, 10'd2, 1'b1, 16'h1002);
      @(negedge clk);
      start = 1'b0;
      while (cyc < e0 + 3) @(negedge clk);
      #1 reset = 1'b1;
      #1 chk_all_zero("mid_reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("t4_sb_drained", 64'(sbq.size()), 64'(0));
      run_load(16'h0200, 10'd8);

      // 5: start held high, second load accepted the cycle after done
      @(negedge clk);
      start = 1'b1; base_addr = 16'h0300; len = 10'd16;
      e0 = cyc + 1;
      push_load(e0, 16'h0300, 10'd16);
      push_load(e0 + 8 + LAT + 1, 16'h0300, 10'd16);
      while (cyc < e0 + 8 + LAT + 1) @(negedge clk);
      start = 1'b0;
      wait_empty("t5_sb_drained");
      repeat (5) @(negedge clk);

      // 6: address wrap across 0xFFFF
      run_load(16'hFFFE, 10'd4);
      chk("t6_addr_wrap", 64'({rom_addr_a, rom_addr_b}), 64'({16'h0000, 16'h0001}));
`ifdef LOADER_CHECKSUM_EN
      chk("t6_checksum", 64'(checksum), 64'(32'h0001_FFFE));
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
